// File: rtl/sumador_pipeline_pkg.sv
// Shared constants for the segmented pipelined adder/subtractor.
package sumador_pipeline_pkg;

  localparam int DEF_BITS     = 16;
  localparam int DEF_SEG_BITS = 4;

  // Bit positions of the status word handed to the result register file.
  localparam int FLAG_CARRY    = 0;
  localparam int FLAG_OVERFLOW = 1;
  localparam int FLAG_ZERO     = 2;
  localparam int FLAG_W        = 3;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  function automatic int num_stages(input int bits, input int seg_bits);
    return bits / seg_bits;
  endfunction

endpackage

// File: rtl/sumador_pipeline_segmento.sv
// One SEG_BITS-wide ripple segment: sum, carry-out and carry into its MSB.
module sumador_pipeline_segmento
  import sumador_pipeline_pkg::*;
#(
  parameter int SEG_BITS = DEF_SEG_BITS
) (
  input  logic [SEG_BITS-1:0] i_a,
  input  logic [SEG_BITS-1:0] i_b,
  input  logic                i_cin,
  output logic [SEG_BITS-1:0] o_sum,
  output logic                o_cout,
  output logic                o_msb_cin
);

  logic [SEG_BITS:0] w_full;

  assign w_full    = {1'b0, i_a} + {1'b0, i_b} + {{SEG_BITS{1'b0}}, i_cin};
  assign o_sum     = w_full[SEG_BITS-1:0];
  assign o_cout    = w_full[SEG_BITS];
  // Carry into the MSB recovered from the MSB sum bit: s = a ^ b ^ cin.
  assign o_msb_cin = i_a[SEG_BITS-1] ^ i_b[SEG_BITS-1] ^ w_full[SEG_BITS-1];

endmodule

// File: rtl/sumador_pipeline.sv
// Pipelined adder/subtractor: one SEG_BITS segment per stage, carry rippling
// stage to stage, valid/ready on both sides with a single global advance.
module sumador_pipeline
  import sumador_pipeline_pkg::*;
#(
  parameter int BITS     = DEF_BITS,
  parameter int SEG_BITS = DEF_SEG_BITS
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [BITS-1:0] A,
  input  logic [BITS-1:0] B,
  input  logic            sub,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [BITS-1:0] R,
  output logic            carry,
  output logic            overflow,
  output logic            zero
);

  localparam int STAGES = num_stages(BITS, SEG_BITS);

  if (SEG_BITS < 1 || (BITS % SEG_BITS) != 0) begin : g_bad_cfg
    $error("sumador_pipeline: BITS must be a non-zero multiple of SEG_BITS");
  end

  op_e             w_op;
  logic            w_adv;
  logic [BITS-1:0] w_b_mod;

  // Per-stage datapath. Operand registers hold the not-yet-added upper
  // segments shifted down, so every stage consumes bits [SEG_BITS-1:0].
  logic [BITS-1:0]     w_a_in     [STAGES];
  logic [BITS-1:0]     w_b_in     [STAGES];
  logic                w_c_in     [STAGES];
  logic                w_v_in     [STAGES];
  logic [SEG_BITS-1:0] w_sum      [STAGES];
  logic                w_cout     [STAGES];
  logic                w_mcin     [STAGES];
  logic [BITS-1:0]     w_res_next [STAGES];

  logic [BITS-1:0]     r_a   [STAGES];
  logic [BITS-1:0]     r_b   [STAGES];
  logic [BITS-1:0]     r_res [STAGES];
  logic                r_c   [STAGES];
  logic                r_v   [STAGES];
  logic [FLAG_W-1:0]   r_flags;

  assign w_op     = op_e'(sub);
  assign w_adv    = !r_v[STAGES-1] || out_ready;
  assign in_ready = w_adv;
  assign w_b_mod  = (w_op == OP_SUB) ? ~B : B;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign w_a_in[k]     = A;
      assign w_b_in[k]     = w_b_mod;
      assign w_c_in[k]     = (w_op == OP_SUB);
      assign w_v_in[k]     = in_valid;
      assign w_res_next[k] = BITS'(w_sum[k]);
    end else begin : g_tail
      assign w_a_in[k]     = r_a[k-1];
      assign w_b_in[k]     = r_b[k-1];
      assign w_c_in[k]     = r_c[k-1];
      assign w_v_in[k]     = r_v[k-1];
      assign w_res_next[k] = r_res[k-1] | (BITS'(w_sum[k]) << (k * SEG_BITS));
    end

    sumador_pipeline_segmento #(
      .SEG_BITS (SEG_BITS)
    ) u_seg (
      .i_a       (w_a_in[k][SEG_BITS-1:0]),
      .i_b       (w_b_in[k][SEG_BITS-1:0]),
      .i_cin     (w_c_in[k]),
      .o_sum     (w_sum[k]),
      .o_cout    (w_cout[k]),
      .o_msb_cin (w_mcin[k])
    );

    // Stage register: shifts valid, carry, partial result and remaining operands.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_v[k]   <= 1'b0;
        r_c[k]   <= 1'b0;
        r_res[k] <= '0;
        r_a[k]   <= '0;
        r_b[k]   <= '0;
      end else if (w_adv) begin
        r_v[k]   <= w_v_in[k];
        r_c[k]   <= w_cout[k];
        r_res[k] <= w_res_next[k];
        r_a[k]   <= w_a_in[k] >> SEG_BITS;
        r_b[k]   <= w_b_in[k] >> SEG_BITS;
      end
    end
  end

  // Status flags registered alongside the last stage so they align with R.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flags <= '0;
    end else if (w_adv) begin
      r_flags[FLAG_CARRY]    <= w_cout[STAGES-1];
      r_flags[FLAG_OVERFLOW] <= w_cout[STAGES-1] ^ w_mcin[STAGES-1];
      r_flags[FLAG_ZERO]     <= (w_res_next[STAGES-1] == '0);
    end
  end

  assign out_valid = r_v[STAGES-1];
  assign R         = r_res[STAGES-1];
  assign carry     = r_flags[FLAG_CARRY];
  assign overflow  = r_flags[FLAG_OVERFLOW];
  assign zero      = r_flags[FLAG_ZERO];

endmodule

// File: doc/sumador_pipeline.md
Name: sumador_pipeline

Overview:
- Parametrised, pipelined adder/subtractor; successor to the combinational 16-bit adder.
- Splits the operands into SEG_BITS-wide segments, with one segment added per pipeline stage and the carry rippling stage to stage.
- Adds a per-operation add/sub mode, status flags (carry, signed overflow, zero) and a valid/ready handshake on both sides.
- Sits between the operand-select logic and the result register file of the datapath.

Parameters:
- BITS, 16, operand/result width; must be a multiple of SEG_BITS.
- SEG_BITS, 4, segment width added per stage; STAGES = BITS/SEG_BITS (derived localparam, not overridable).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand beat present
- in_ready  out  1  block accepts operand beat this cycle
- A  in  BITS  operand A
- B  in  BITS  operand B
- sub  in  1  0: R=A+B; 1: R=A-B
- out_valid  out  1  result beat present
- out_ready  in  1  consumer accepts result this cycle
- R  out  BITS  result
- carry  out  1  carry out of MSB (for sub: 1 = no borrow)
- overflow  out  1  two's-complement signed overflow
- zero  out  1  R == 0

Behaviour:
- Reset (rst_n low, async): all stage valid bits, out_valid, R, carry, overflow and zero go to 0. in_ready follows its formula (1 after reset). In-flight operations are discarded, with no partial result ever presented.
- Global advance: adv = !out_valid || out_ready; in_ready = adv (combinational, no dependence on in_valid).
- Accept: an operand beat is captured when in_valid && in_ready. When adv=0 every stage register holds, and A/B/sub are ignored.
- Stage 0 operation:
  - computes segment 0 of A + (sub ? ~B : B) + sub;
  - stores the SEG_BITS sum, the carry, the sub bit and the valid bit;
  - registers the remaining upper segments of A and B' (B' = B inverted when sub=1).
- Stage k (k ≥ 1): adds segment k of the delayed A/B' plus the carry from stage k-1. Lower result segments are carried forward unchanged (skew registers).
- Latency: exactly STAGES cycles from accept to out_valid when unstalled. Throughput is 1 beat/cycle.
- Bubbles (valid=0) advance with adv like data. Results leave in acceptance order, and none are dropped or duplicated.
- Output: R, carry, overflow and zero are registered, and stable while out_valid && !out_ready.
- Flag definitions:
  - carry = carry out of the final segment;
  - overflow = carry into MSB XOR carry out of MSB;
  - zero = (R == 0).
- Wrap-around: result is modulo 2^BITS.
- Simultaneous events: an output handshake and an input accept in the same cycle are both legal.
- SEG_BITS == BITS: single stage, latency 1.

Decomposition:
- Shared header (sumador_defs): default BITS/SEG_BITS constants, STAGES computation, flag bit indices for the status word consumed by the register file.
- One natural sub-module, sumador_segmento: SEG_BITS adder with carry-in, sum, carry-out and MSB carry-in output (for overflow). Instantiated STAGES times by generate.

Test Plan (BITS=16, SEG_BITS=4, so latency 4):
- A=16'h7FFF, B=16'h0001, sub=0 -> 4 cycles later R=16'h8000, carry=0, overflow=1, zero=0.
- A=16'hFFFF, B=16'h0001, sub=0 -> R=16'h0000, carry=1, overflow=0, zero=1.
- A=16'h0003, B=16'h0005, sub=1 -> R=16'hFFFE, carry=0 (borrow), overflow=0. Also A=16'h8000, B=16'h0001, sub=1 -> R=16'h7FFF, overflow=1, carry=1.
- Back-to-back stream of 8 beats (A=i, B=2i), out_ready held 0 for cycles 5-7 -> in_ready low during the stall, R sequence 0,3,6,...,21 in order with no loss or duplication, R stable while stalled.
- rst_n pulsed low for 1 cycle with 3 beats in flight -> out_valid=0 immediately, R=0, flags 0; the next accepted beat appears exactly 4 cycles after acceptance.
- 50 random A/B/sub beats with random out_ready -> every R and flag matches a reference model computed at acceptance time.
